fb_write_arbiter: RTL and testbench

//  Shares the single framebuffer RAM write port between N pixel producers
//  (map renderer, sprite renderer, text box) with round-robin arbitration.

---
 rtl/fb_write_arbiter.sv | 121 ++++++++++++
 tb/tb_fb_write_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing the framebuffer write port between N_REQ producers,
// with per-frame pixel counting. Optional colour-key skipping under FB_TRANSPARENCY_EN.
module fb_write_arbiter #(
    parameter int                N_REQ        = 3,
    parameter int                ADDR_W       = 19,
    parameter int                DATA_W       = 24,
    parameter int                FRAME_PIXELS = 38400,
    parameter logic [DATA_W-1:0] TRANSPARENT  = 24'hFF00FF
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     frame_start,
    input  logic                     write_window,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     fb_we,
    output logic [ADDR_W-1:0]        fb_addr,
    output logic [DATA_W-1:0]        fb_data,
    output logic                     frame_done,
    output logic                     overrun
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
    localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PIXELS);

`ifdef FB_TRANSPARENCY_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_inc;
    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic               arb_en;
    logic               transfer;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               skip_write;

    assign arb_en     = (state == RUN) && write_window;
    assign transfer   = arb_en && grant_found;
    assign count_inc  = count + 1'b1;
    assign sel_addr   = req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign sel_data   = req_data[grant_idx*DATA_W +: DATA_W];
    assign skip_write = TRANSP_EN && (sel_data == TRANSPARENT);

    // Search starts one past the last winner so every producer gets a turn.
    always_comb begin
        // NOTE: defaults first keep every path assigned, so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!grant_found && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (frame_start) state_nxt = RUN;
            RUN: begin
                if (frame_start)                               state_nxt = RUN;
                else if (transfer && (count_inc == CNT_LAST))  state_nxt = DONE;
            end
            DONE: if (frame_start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        frame_done = (state == DONE);
        if (transfer) req_ready[grant_idx] = 1'b1;
    end

    // A frame_start coinciding with a transfer restarts the count, but the pixel is still written.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rr_ptr  <= PTR_INIT;
            count   <= '0;
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= (state == RUN) && frame_start;
            fb_we   <= transfer && !skip_write;
            if (transfer) begin
                fb_addr <= sel_addr;
                fb_data <= sel_data;
            end
            if (frame_start) begin
                count <= '0;
                if (state != DONE) rr_ptr <= PTR_INIT;
            end else if (transfer) begin
                rr_ptr <= grant_idx;
                count  <= count_inc;
            end
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter: expected writes are queued per cycle and
// compared against fb_we/addr/data one cycle later.
module tb_fb_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 19;
    localparam int DW = 24;
    localparam int FP = 4;
    localparam logic [DW-1:0] KEY = 24'hFF00FF;

`ifdef FB_TRANSPARENCY_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              Reset;
    logic              frame_start;
    logic              write_window;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fb_we;
    logic [AW-1:0]     fb_addr;
    logic [DW-1:0]     fb_data;
    logic              frame_done;
    logic              overrun;

    logic [AW-1:0]     a_q [N];
    logic [DW-1:0]     d_q [N];

    typedef struct {
        logic          we;
        logic          full;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t sb[$];
    int  errors = 0;
    int  checks = 0;

    fb_write_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .FRAME_PIXELS(FP), .TRANSPARENT(KEY)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .write_window(write_window),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = a_q[i];
            req_data[i*DW +: DW] = d_q[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_fb(input string tag);
        wr_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, ".fb_we"}, 64'(fb_we), 64'(e.we));
            if (e.full) begin
                check({tag, ".fb_addr"}, 64'(fb_addr), 64'(e.addr));
                check({tag, ".fb_data"}, 64'(fb_data), 64'(e.data));
            end
        end
    endtask

    // One clock: check outputs at the negedge, queue the write this cycle should cause.
    task automatic step(input logic [N-1:0] exp_ready, input logic exp_done,
                        input logic exp_ovr, input string tag);
        wr_t e;
        int  g;
        @(negedge Clk);
        check_fb(tag);
        check({tag, ".ready"}, 64'(req_ready), 64'(exp_ready));
        check({tag, ".done"},  64'(frame_done), 64'(exp_done));
        check({tag, ".ovr"},   64'(overrun), 64'(exp_ovr));
        g = -1;
        for (int i = 0; i < N; i++)
            if (exp_ready[i] && req_valid[i]) g = i;
        e.we = 1'b0; e.full = 1'b0; e.addr = '0; e.data = '0;
        if (g >= 0) begin
            e.we   = !(TEN && (d_q[g] == KEY));
            e.full = e.we;
            e.addr = a_q[g];
            e.data = d_q[g];
        end
        sb.push_back(e);
        @(posedge Clk);
        #1;
        if (g >= 0) begin
            a_q[g] = AW'($urandom());
            d_q[g] = DW'($urandom());
        end
    endtask

    task automatic async_reset(input string tag);
        wr_t e;
        #2 Reset = 1'b1;
        #1;
        check({tag, ".fb_we"},   64'(fb_we), 64'd0);
        check({tag, ".fb_addr"}, 64'(fb_addr), 64'd0);
        check({tag, ".fb_data"}, 64'(fb_data), 64'd0);
        check({tag, ".ready"},   64'(req_ready), 64'd0);
        check({tag, ".done"},    64'(frame_done), 64'd0);
        check({tag, ".ovr"},     64'(overrun), 64'd0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        sb.delete();
        e.we = 1'b0; e.full = 1'b1; e.addr = '0; e.data = '0;
        sb.push_back(e);
    endtask

    initial begin
        Reset = 1'b0; frame_start = 1'b0; write_window = 1'b0; req_valid = '0;
        for (int i = 0; i < N; i++) begin
            a_q[i] = AW'(32'h100 + i);
            d_q[i] = DW'(32'hA0000 + i);
        end
        @(posedge Clk); #1;

        // Reset and IDLE: no grants even with everything valid
        async_reset("t1_rst");
        req_valid = 3'b111; write_window = 1'b1;
        step(3'b000, 1'b0, 1'b0, "t1_idle");

        // Round robin across all three requesters
        frame_start = 1'b1;
        step(3'b000, 1'b0, 1'b0, "t2_fs");
        frame_start = 1'b0;
        step(3'b001, 1'b0, 1'b0, "t2_g0");
        step(3'b010, 1'b0, 1'b0, "t2_g1");
        step(3'b100, 1'b0, 1'b0, "t2_g2");
        step(3'b001, 1'b0, 1'b0, "t2_g0b");
        step(3'b000, 1'b1, 1'b0, "t2_done");

        // Single requester completes a frame, then restart
        req_valid = 3'b010; frame_start = 1'b1;
        step(3'b000, 1'b1, 1'b0, "t3_fs");
        frame_start = 1'b0;
        repeat (FP) step(3'b010, 1'b0, 1'b0, "t3_g1");
        step(3'b000, 1'b1, 1'b0, "t3_done");
        step(3'b000, 1'b1, 1'b0, "t3_hold");

        // Write window gap: count held across it
        req_valid = 3'b001; frame_start = 1'b1;
        step(3'b000, 1'b1, 1'b0, "t4_fs");
        frame_start = 1'b0;
        step(3'b001, 1'b0, 1'b0, "t4_pre");
        write_window = 1'b0;
        step(3'b000, 1'b0, 1'b0, "t4_gap");
        step(3'b000, 1'b0, 1'b0, "t4_gap");
        write_window = 1'b1;
        repeat (3) step(3'b001, 1'b0, 1'b0, "t4_post");
        step(3'b000, 1'b1, 1'b0, "t4_done");

        // Overrun after two transfers; restart resets count and pointer
        frame_start = 1'b1;
        step(3'b000, 1'b1, 1'b0, "t5_fs");
        frame_start = 1'b0;
        step(3'b001, 1'b0, 1'b0, "t5_a");
        step(3'b001, 1'b0, 1'b0, "t5_b");
        frame_start = 1'b1; write_window = 1'b0;
        step(3'b000, 1'b0, 1'b0, "t5_ovfs");
        frame_start = 1'b0; write_window = 1'b1; req_valid = 3'b111;
        step(3'b001, 1'b0, 1'b1, "t5_ovr");
        step(3'b010, 1'b0, 1'b0, "t5_g1");
        step(3'b100, 1'b0, 1'b0, "t5_g2");
        // frame_start together with the final transfer: restart wins, pixel still written
        frame_start = 1'b1;
        step(3'b001, 1'b0, 1'b0, "t5_finfs");
        frame_start = 1'b0;
        step(3'b001, 1'b0, 1'b1, "t5_rst0");
        step(3'b010, 1'b0, 1'b0, "t5_r1");
        step(3'b100, 1'b0, 1'b0, "t5_r2");
        step(3'b001, 1'b0, 1'b0, "t5_r3");
        step(3'b000, 1'b1, 1'b0, "t5_done");

        // Colour-key pixel: accepted and counted, written only when the feature is off
        req_valid = 3'b001; frame_start = 1'b1;
        step(3'b000, 1'b1, 1'b0, "t6_fs");
        frame_start = 1'b0;
        d_q[0] = KEY;
        step(3'b001, 1'b0, 1'b0, "t6_key");
        d_q[0] = 24'h123456;
        step(3'b001, 1'b0, 1'b0, "t6_pix");
        step(3'b001, 1'b0, 1'b0, "t6_c");
        step(3'b001, 1'b0, 1'b0, "t6_d");
        step(3'b000, 1'b1, 1'b0, "t6_done");

        // Reset mid-frame with a write pending
        frame_start = 1'b1;
        step(3'b000, 1'b1, 1'b0, "t7_fs");
        frame_start = 1'b0;
        step(3'b001, 1'b0, 1'b0, "t7_g0");
        async_reset("t7_rst");
        step(3'b000, 1'b0, 1'b0, "t7_idle");
        frame_start = 1'b1;
        step(3'b000, 1'b0, 1'b0, "t7_fs2");
        frame_start = 1'b0;
        step(3'b001, 1'b0, 1'b0, "t7_g0b");
        step(3'b001, 1'b0, 1'b0, "t7_g0c");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
